// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and defaults for the RegFile dump reader slice.
package regfile_dump_reader_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned REG_ZERO       = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready stream of {addr,data,last} register dump entries.
interface regfile_dump_reader_if
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/regfile_snoop_bypass.sv
// Combinational write-first view of one register: snooped write wins over RegFile read data.
module regfile_snoop_bypass
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit          ZERO_HARD  = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] rf_rd,
  input  logic                  rf_we,
  input  logic [ADDR_WIDTH-1:0] rf_wa,
  input  logic [DATA_WIDTH-1:0] rf_wd,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  hit
);

  logic is_zero;

  always_comb begin
    is_zero = ZERO_HARD && (addr == ADDR_WIDTH'(REG_ZERO));
    hit     = rf_we && (rf_wa == addr) && !is_zero;
    value   = rf_rd;
    if (is_zero) begin
      value = '0;
    end else if (hit) begin
      value = rf_wd;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks RegFile addresses first..last through one async read port and streams {addr,data}.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit          ZERO_HARD  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_ra,
  input  logic [DATA_WIDTH-1:0] rf_rd,
  input  logic                  rf_we,
  input  logic [ADDR_WIDTH-1:0] rf_wa,
  input  logic [DATA_WIDTH-1:0] rf_wd,
  regfile_dump_reader_if.master dump
);

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur;
  logic [ADDR_WIDTH-1:0] end_addr;
  logic                  issued_last;
  logic                  range_ok;
  logic                  capture;
  logic                  hs;
  logic                  last_hs;

  logic [DATA_WIDTH-1:0] cap_value;
  logic                  cap_hit_unused;
  logic [DATA_WIDTH-1:0] hold_value;
  logic                  hold_hit;

  regfile_snoop_bypass #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ZERO_HARD  (ZERO_HARD)
  ) u_cap_bypass (
    .addr  (cur),
    .rf_rd (rf_rd),
    .rf_we (rf_we),
    .rf_wa (rf_wa),
    .rf_wd (rf_wd),
    .value (cap_value),
    .hit   (cap_hit_unused)
  );

  // Held entry refresh: feeding the current out_data as "read data" keeps it unless a write hits.
  regfile_snoop_bypass #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ZERO_HARD  (ZERO_HARD)
  ) u_hold_bypass (
    .addr  (dump.out_addr),
    .rf_rd (dump.out_data),
    .rf_we (rf_we),
    .rf_wa (rf_wa),
    .rf_wd (rf_wd),
    .value (hold_value),
    .hit   (hold_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    rf_ra     = '0;
    capture   = 1'b0;
    range_ok  = (first_addr <= last_addr);
    hs        = dump.out_valid && dump.out_ready;
    last_hs   = hs && dump.out_last;
    unique case (state)
      ST_IDLE: begin
        if (start && range_ok) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy    = 1'b1;
        rf_ra   = cur;
        capture = !issued_last && (!dump.out_valid || dump.out_ready);
        if (last_hs) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // issued_last, not cur>end, ends issuing so a dump up to the top address cannot wrap to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur            <= '0;
      end_addr       <= '0;
      issued_last    <= 1'b0;
      done           <= 1'b0;
      dump.out_valid <= 1'b0;
      dump.out_addr  <= '0;
      dump.out_data  <= '0;
      dump.out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE && start) begin
        if (range_ok) begin
          cur         <= first_addr;
          end_addr    <= last_addr;
          issued_last <= 1'b0;
        end else begin
          done <= 1'b1;
        end
      end
      if (last_hs) begin
        done <= 1'b1;
      end
      if (capture) begin
        dump.out_valid <= 1'b1;
        dump.out_addr  <= cur;
        dump.out_data  <= cap_value;
        dump.out_last  <= (cur == end_addr);
        cur            <= cur + 1'b1;
        if (cur == end_addr) begin
          issued_last <= 1'b1;
        end
      end else if (hs) begin
        dump.out_valid <= 1'b0;
      end else if (dump.out_valid && hold_hit) begin
        dump.out_data <= hold_value;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural RegFile and stream collector.
module tb_regfile_dump_reader;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
    int          c;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic        busy;
  logic        done;
  logic [4:0]  rf_ra;
  logic [31:0] rf_rd;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  logic [31:0] rf_mem [32];
  logic [31:0] exp_rf [32];

  entry_t      q[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  int          rdy_mode = 0;
  int          stall_cnt = 0;
  logic        tog = 1'b1;
  logic        stab_en = 1'b0;
  logic        busy_seen = 1'b0;
  int          hk_n = 0;
  logic [4:0]  hk_addr [2];
  logic [31:0] hk_data [2];

  regfile_dump_reader_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dif ();

  regfile_dump_reader #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32),
    .ZERO_HARD  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .busy       (busy),
    .done       (done),
    .rf_ra      (rf_ra),
    .rf_rd      (rf_rd),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .dump       (dif)
  );

  always #5 clk = ~clk;

  assign rf_rd = rf_mem[rf_ra];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic init_regs();
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = 32'h1000 + 32'(i);
      exp_rf[i] = 32'h1000 + 32'(i);
    end
    rf_mem[0] = 32'h0000_0BAD;
  endtask

  // One clock: drive ready/writes, log the handshake about to happen, advance, observe.
  task automatic step();
    entry_t      e;
    logic        held;
    logic [37:0] snap;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    we = 1'b0;
    wa = '0;
    wd = '0;
    case (rdy_mode)
      0: dif.out_ready = 1'b1;
      1: begin
        dif.out_ready = tog;
        tog = ~tog;
      end
      default: begin
        if (dif.out_valid && dif.out_addr == 5'd9 && stall_cnt < 3) begin
          dif.out_ready = 1'b0;
          if (stall_cnt == 1) begin
            we = 1'b1;
            wa = 5'd9;
            wd = 32'hDEAD_BEEF;
          end
          stall_cnt++;
        end else begin
          dif.out_ready = 1'b1;
        end
      end
    endcase
    if (busy) begin
      for (int i = 0; i < hk_n; i++) begin
        if (rf_ra == hk_addr[i]) begin
          we = 1'b1;
          wa = hk_addr[i];
          wd = hk_data[i];
        end
      end
    end
    rf_we = we;
    rf_wa = wa;
    rf_wd = wd;
    if (dif.out_valid && dif.out_ready && !rst) begin
      e.a = dif.out_addr;
      e.d = dif.out_data;
      e.l = dif.out_last;
      e.c = cyc;
      q.push_back(e);
    end
    held = stab_en && dif.out_valid && !dif.out_ready && !rst;
    snap = {dif.out_addr, dif.out_data, dif.out_last};
    @(posedge clk);
    #1;
    cyc++;
    if (we) rf_mem[wa] = wd;
    if (held) check("stall_stable", {dif.out_addr, dif.out_data, dif.out_last}, snap);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_seen = 1'b1;
    if (rdy_mode == 2 && we) begin
      check("held_refresh_data", dif.out_data, 32'hDEAD_BEEF);
      check("held_refresh_addr", dif.out_addr, 5'd9);
    end
  endtask

  task automatic run_dump(input int f, input int l);
    q.delete();
    done_cnt  = 0;
    busy_seen = 1'b0;
    first_addr = 5'(f);
    last_addr  = 5'(l);
    start = 1'b1;
    step();
    start = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < 200 && done_cnt == 0; i++) step();
    step();
    step();
  endtask

  task automatic verify(input string tag, input int f, input int l);
    int n;
    n = (l >= f) ? (l - f + 1) : 0;
    check({tag, "_count"}, 64'(q.size()), 64'(n));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    for (int i = 0; i < q.size() && i < n; i++) begin
      int a;
      a = f + i;
      check($sformatf("%s_addr%0d", tag, a), q[i].a, 64'(a));
      check($sformatf("%s_data%0d", tag, a), q[i].d, (a == 0) ? 64'd0 : 64'(exp_rf[a]));
      check($sformatf("%s_last%0d", tag, a), q[i].l, (a == l) ? 64'd1 : 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    first_addr = '0;
    last_addr = '0;
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    dif.out_ready = 1'b0;
    init_regs();
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", dif.out_valid, 0);
    check("rst_addr", dif.out_addr, 0);
    check("rst_data", dif.out_data, 0);
    check("rst_last", dif.out_last, 0);
    check("rst_ra", rf_ra, 0);
    rst = 1'b0;
    step();

    // Full dump, continuous ready
    rdy_mode = 0;
    run_dump(0, 31);
    verify("full", 0, 31);
    if (q.size() == 32) begin
      check("full_latency", 64'(q[0].c), 64'(start_cyc + 1));
      check("full_b2b", 64'(q[31].c - q[0].c), 64'd31);
      check("full_done_cyc", 64'(done_cyc), 64'(q[31].c + 1));
    end
    check("full_busy_after", busy, 0);

    // Backpressure with toggling ready
    rdy_mode = 1;
    stab_en = 1'b1;
    tog = 1'b0;
    run_dump(3, 5);
    verify("bp", 3, 5);
    stab_en = 1'b0;

    // Write-first bypass during capture, including hard-zero x0
    rdy_mode = 0;
    init_regs();
    hk_n = 2;
    hk_addr[0] = 5'd7;
    hk_data[0] = 32'hFEED_ABBA;
    hk_addr[1] = 5'd0;
    hk_data[1] = 32'h000F_FFFF;
    exp_rf[7] = 32'hFEED_ABBA;
    run_dump(0, 31);
    verify("byp", 0, 31);
    hk_n = 0;

    // Held entry refresh on snooped write
    init_regs();
    rdy_mode = 2;
    stall_cnt = 0;
    exp_rf[9] = 32'hDEAD_BEEF;
    run_dump(8, 10);
    verify("hold", 8, 10);
    check("hold_stalls", 64'(stall_cnt), 64'd3);
    rdy_mode = 0;
    init_regs();

    // Single top-address entry
    run_dump(31, 31);
    verify("top", 31, 31);

    // Empty range
    run_dump(5, 2);
    verify("empty", 5, 2);
    check("empty_busy_never", busy_seen, 0);

    // Reset in the middle of a dump
    q.delete();
    first_addr = 5'd0;
    last_addr  = 5'd31;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100 && q.size() < 11; i++) step();
    check("mid_reach", 64'(q.size()), 64'd11);
    done_cnt = 0;
    rst = 1'b1;
    step();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", dif.out_valid, 0);
    check("mid_rst_addr", dif.out_addr, 0);
    check("mid_rst_data", dif.out_data, 0);
    check("mid_rst_last", dif.out_last, 0);
    check("mid_rst_ra", rf_ra, 0);
    rst = 1'b0;
    step();
    step();
    step();
    check("mid_no_done", 64'(done_cnt), 64'd0);
    check("mid_idle_valid", dif.out_valid, 0);
    run_dump(3, 4);
    verify("after_rst", 3, 4);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
